attr_record_decoder: RTL and testbench
======================================

Name: attr_record_decoder

Overview:
Consumer end of the packet-attribute interface driven by the protocol-combination analyzers.
- Captures each pkt_valid/pkt_attributes pulse into a small record queue.
- Unpacks the 135-bit attribute vector into named fields.
- Presents one record at a time downstream with a valid/ready handshake.
- Sits between the analyzer bank and the stats/host-export logic; absorbs bursts when the consumer stalls and counts records lost to overflow.

Parameters:
ATTRIBUTE_DATA_WIDTH, 135, width of incoming attribute vector
NUM_INPUT_QUEUES, 8, width of one-hot input-interface field
PRTCL_ID_WIDTH, 2, protocol-combination priority ID width
BYTES_COUNT_WIDTH, 16, packet byte-count field width
PKT_FLAGS_WIDTH, 5, packet flags field width
FIFO_DEPTH_BITS, 3, log2 of queue memory depth (8 entries)

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-high
in_pkt_valid  in  1  one-cycle pulse, attribute record present
in_pkt_attributes  in  ATTRIBUTE_DATA_WIDTH  packed record
out_valid  out  1  head record valid
out_ready  in  1  consumer accepts head record
out_proto  out  8  IP protocol, bits [7:0]
out_ip_src  out  32  bits [39:8]
out_ip_dst  out  32  bits [71:40]
out_port_src  out  16  bits [87:72]
out_port_dst  out  16  bits [103:88]
out_bytes  out  BYTES_COUNT_WIDTH  bits [119:104]
out_flags  out  PKT_FLAGS_WIDTH  bits [124:120]
out_prtcl_id  out  PRTCL_ID_WIDTH  bits [126:125]
out_input_if  out  NUM_INPUT_QUEUES  bits [134:127], raw one-hot
out_input_port  out  clog2(NUM_INPUT_QUEUES)  binary index of out_input_if
out_if_err  out  1  out_input_if not exactly one-hot
clear_counters  in  1  synchronous clear of all counters
drop_count  out  32  records dropped on overflow, saturating
fifo_full  out  1  queue memory full
fifo_empty  out  1  queue memory empty
prtcl_counts  out  4*32  per-prtcl_id accepted counts (optional feature)

Behaviour:
- Reset (async) values: out_valid=0, all out_* fields=0, drop_count=0, fifo_full=0, fifo_empty=1, prtcl_counts=0. Pointers are cleared and queued records are discarded, taking effect immediately, including mid-drain.
- Storage: memory of 2^FIFO_DEPTH_BITS entries plus a registered output stage. Total capacity is 2^FIFO_DEPTH_BITS+1 records. Records leave strictly in arrival order.
- Push: in_pkt_valid=1 and memory not full. The record is written unmodified.
- Full push:
  - If the memory is full, the output stage is valid, and no pop occurs that cycle, the record is dropped and drop_count increments.
  - If a pop occurs in the same cycle, the push is accepted with no drop.
- Output stage, states EMPTY / LOADED:
  - EMPTY -> LOADED when memory is non-empty; the head is loaded, out_valid=1 next cycle.
  - LOADED with out_valid&out_ready: reload from memory if non-empty, else -> EMPTY.
  - LOADED with !out_ready: all out_* fields are held stable.
- Latency: with empty queue, push at cycle N gives out_valid=1 at N+2. Sustained throughput is one record per cycle when out_ready=1.
- Decode: all fields are registered with the output stage.
  - out_input_port = index of the set bit.
  - If zero bits or more than one bit are set: out_if_err=1 and out_input_port=0.
- drop_count saturates at 0xFFFFFFFF. clear_counters has priority over a same-cycle increment.
- fifo_full/fifo_empty are registered, reflect memory only, and update in the cycle after push/pop.

Optional Feature:
ATTR_DECODER_STATS_EN
- Defined: four 32-bit wrap-around counters, indexed by in_prtcl_id bits of the record.
  - Each counter increments on an accepted push of a record with that ID; dropped records are not counted.
  - clear_counters zeroes all four; clear wins over a same-cycle increment.
  - Packed on prtcl_counts with ID 0 in [31:0].
- Undefined: prtcl_counts is tied to 0 and no counter logic is built.

Decomposition:
- Shared package/defines: field offsets and widths (PROTO/IP/PORT/BYTES/FLAGS/PRTCL_ID/INPUT_IF) and PRTCL_ID priority values, shared with the analyzers so both ends use one layout.
- Sub-module attr_record_fifo: synchronous memory FIFO with full/empty and simultaneous push/pop. Decode, output stage and counters stay in the top.

Test Plan:
1. Single record: proto=0x06, ip_src=0x0A000001, ip_dst=0x0A000002, ports 0x1234/0x0050, bytes=64, flags=0x03, prtcl_id=2, input_if=0x04, out_ready=0 -> out_valid at N+2, all fields match, out_input_port=2, out_if_err=0, fields stable over 10 cycles; then out_ready=1 -> out_valid=0 next cycle, fifo_empty=1.
2. Overflow: out_ready=0, 12 back-to-back pushes, byte counts 1..12 -> fifo_full=1, drop_count=3; drain with out_ready=1 -> bytes 1..9 in order, then out_valid=0.
3. Full with simultaneous pop and push -> push accepted, drop_count unchanged, next drained records keep arrival order.
4. input_if=0x00, then 0x05 -> out_if_err=1, out_input_port=0 for both; input_if=0x80 -> out_input_port=7, out_if_err=0.
5. clear_counters asserted in the same cycle as an overflow drop, with drop_count=3 -> drop_count=0. With ATTR_DECODER_STATS_EN: 3 pushes with prtcl_id=1 and 1 with prtcl_id=3 -> prtcl_counts[63:32]=3, [127:96]=1.
6. Reset mid-drain with 5 records queued -> out_valid=0 and fifo_empty=1 immediately; after release, one new push emerges alone at N+2.

Source files
------------

// File: rtl/attr_record_decoder_pkg.sv
// Shared attribute-record layout for the analyzers and the record decoder.
// Field offsets/widths, priority IDs and the record unpack/decode helper.
package attr_record_decoder_pkg;

  localparam int ATTR_W      = 135;
  localparam int NUM_IF      = 8;
  localparam int PORT_IDX_W  = $clog2(NUM_IF);
  localparam int ONES_W      = $clog2(NUM_IF + 1);

  localparam int PROTO_LSB    = 0;
  localparam int PROTO_W      = 8;
  localparam int IP_SRC_LSB   = 8;
  localparam int IP_DST_LSB   = 40;
  localparam int IP_W         = 32;
  localparam int PORT_SRC_LSB = 72;
  localparam int PORT_DST_LSB = 88;
  localparam int L4_PORT_W    = 16;
  localparam int BYTES_LSB    = 104;
  localparam int BYTES_W      = 16;
  localparam int FLAGS_LSB    = 120;
  localparam int FLAGS_W      = 5;
  localparam int PRTCL_LSB    = 125;
  localparam int PRTCL_W      = 2;
  localparam int INPUT_IF_LSB = 127;

  typedef enum logic [PRTCL_W-1:0] {
    PRTCL_PRIO_LOW  = 2'd0,
    PRTCL_PRIO_MID  = 2'd1,
    PRTCL_PRIO_HIGH = 2'd2,
    PRTCL_PRIO_TOP  = 2'd3
  } prtcl_prio_e;

  typedef enum logic {
    OUT_EMPTY,
    OUT_LOADED
  } out_state_e;

  typedef struct packed {
    logic [NUM_IF-1:0]     input_if;
    logic [PORT_IDX_W-1:0] input_port;
    logic                  if_err;
    logic [PRTCL_W-1:0]    prtcl_id;
    logic [FLAGS_W-1:0]    flags;
    logic [BYTES_W-1:0]    bytes;
    logic [L4_PORT_W-1:0]  port_dst;
    logic [L4_PORT_W-1:0]  port_src;
    logic [IP_W-1:0]       ip_dst;
    logic [IP_W-1:0]       ip_src;
    logic [PROTO_W-1:0]    proto;
  } attr_rec_t;

  function automatic attr_rec_t decode_attr(
    input logic [ATTR_W-1:0] a
  );
    attr_rec_t             r;
    logic [NUM_IF-1:0]     ifv;
    logic [ONES_W-1:0]     ones;
    logic [PORT_IDX_W-1:0] idx;
    ifv  = a[INPUT_IF_LSB +: NUM_IF];
    ones = '0;
    idx  = '0;
    for (int i = 0; i < NUM_IF; i++) begin
      if (ifv[i]) begin
        ones = ones + ONES_W'(1);
        idx  = PORT_IDX_W'(i);
      end
    end
    r.input_if   = ifv;
    r.if_err     = (ones != ONES_W'(1));
    // Malformed one-hot reports port 0 alongside the error flag.
    r.input_port = r.if_err ? '0 : idx;
    r.prtcl_id   = a[PRTCL_LSB +: PRTCL_W];
    r.flags      = a[FLAGS_LSB +: FLAGS_W];
    r.bytes      = a[BYTES_LSB +: BYTES_W];
    r.port_dst   = a[PORT_DST_LSB +: L4_PORT_W];
    r.port_src   = a[PORT_SRC_LSB +: L4_PORT_W];
    r.ip_dst     = a[IP_DST_LSB +: IP_W];
    r.ip_src     = a[IP_SRC_LSB +: IP_W];
    r.proto      = a[PROTO_LSB +: PROTO_W];
    return r;
  endfunction

endpackage

// File: rtl/attr_record_fifo.sv
// Synchronous memory FIFO for raw attribute records.
// Registered full/empty; a push into a full memory is taken when a pop coincides.
module attr_record_fifo
  import attr_record_decoder_pkg::*;
#(
  parameter int W  = ATTR_W,
  parameter int AW = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         push_ok,
  output logic         full,
  output logic         empty
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic          do_pop;

  assign do_pop  = pop & ~empty;
  assign push_ok = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    unique case ({push_ok, do_pop})
      2'b10:   count_nxt = count + (AW+1)'(1);
      2'b01:   count_nxt = count - (AW+1)'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == (AW+1)'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/attr_record_decoder.sv
// Attribute-record consumer: queue, field decode, valid/ready output stage.
// Define ATTR_DECODER_STATS_EN to build the per-prtcl_id accepted counters.
module attr_record_decoder
  import attr_record_decoder_pkg::*;
#(
  parameter int ATTRIBUTE_DATA_WIDTH = 135,
  parameter int NUM_INPUT_QUEUES     = 8,
  parameter int PRTCL_ID_WIDTH       = 2,
  parameter int BYTES_COUNT_WIDTH    = 16,
  parameter int PKT_FLAGS_WIDTH      = 5,
  parameter int FIFO_DEPTH_BITS      = 3
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_pkt_valid,
  input  logic [ATTRIBUTE_DATA_WIDTH-1:0]     in_pkt_attributes,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [7:0]                          out_proto,
  output logic [31:0]                         out_ip_src,
  output logic [31:0]                         out_ip_dst,
  output logic [15:0]                         out_port_src,
  output logic [15:0]                         out_port_dst,
  output logic [BYTES_COUNT_WIDTH-1:0]        out_bytes,
  output logic [PKT_FLAGS_WIDTH-1:0]          out_flags,
  output logic [PRTCL_ID_WIDTH-1:0]           out_prtcl_id,
  output logic [NUM_INPUT_QUEUES-1:0]         out_input_if,
  output logic [$clog2(NUM_INPUT_QUEUES)-1:0] out_input_port,
  output logic                                out_if_err,
  input  logic                                clear_counters,
  output logic [31:0]                         drop_count,
  output logic                                fifo_full,
  output logic                                fifo_empty,
  output logic [4*32-1:0]                     prtcl_counts
);

  out_state_e                      state;
  out_state_e                      state_nxt;
  logic                            load;
  logic                            push_ok;
  logic                            drop;
  logic [ATTRIBUTE_DATA_WIDTH-1:0] head;
  attr_rec_t                       rec_q;

  attr_record_fifo #(
    .W  (ATTRIBUTE_DATA_WIDTH),
    .AW (FIFO_DEPTH_BITS)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (in_pkt_valid),
    .pop     (load),
    .wdata   (in_pkt_attributes),
    .rdata   (head),
    .push_ok (push_ok),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // A full memory implies a head to move, so a drop needs no pop that cycle.
  assign drop = in_pkt_valid & ~push_ok;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    unique case (state)
      OUT_EMPTY: begin
        if (!fifo_empty) begin
          load      = 1'b1;
          state_nxt = OUT_LOADED;
        end
      end
      OUT_LOADED: begin
        if (out_ready) begin
          if (!fifo_empty) load = 1'b1;
          else             state_nxt = OUT_EMPTY;
        end
      end
      default: state_nxt = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= OUT_EMPTY;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     rec_q <= '0;
    else if (load) rec_q <= decode_attr(head);
  end

  assign out_valid      = (state == OUT_LOADED);
  assign out_proto      = rec_q.proto;
  assign out_ip_src     = rec_q.ip_src;
  assign out_ip_dst     = rec_q.ip_dst;
  assign out_port_src   = rec_q.port_src;
  assign out_port_dst   = rec_q.port_dst;
  assign out_bytes      = rec_q.bytes;
  assign out_flags      = rec_q.flags;
  assign out_prtcl_id   = rec_q.prtcl_id;
  assign out_input_if   = rec_q.input_if;
  assign out_input_port = rec_q.input_port;
  assign out_if_err     = rec_q.if_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   drop_count <= '0;
    else if (clear_counters)     drop_count <= '0;
    else if (drop && drop_count != '1)
      drop_count <= drop_count + 32'd1;
  end

`ifdef ATTR_DECODER_STATS_EN
  logic [31:0]         prtcl_cnt [4];
  logic [PRTCL_W-1:0]  in_id;

  assign in_id = in_pkt_attributes[PRTCL_LSB +: PRTCL_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) prtcl_cnt[i] <= '0;
    end else if (clear_counters) begin
      for (int i = 0; i < 4; i++) prtcl_cnt[i] <= '0;
    end else if (push_ok) begin
      prtcl_cnt[in_id] <= prtcl_cnt[in_id] + 32'd1;
    end
  end

  always_comb begin
    prtcl_counts = '0;
    for (int i = 0; i < 4; i++) prtcl_counts[i*32 +: 32] = prtcl_cnt[i];
  end
`else
  assign prtcl_counts = '0;
`endif

endmodule

// File: tb/tb_attr_record_decoder.sv
// Scoreboard bench for attr_record_decoder: latency, overflow,
// full push/pop, one-hot decode, counter clear and mid-drain reset.
module tb_attr_record_decoder;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_pkt_valid = 1'b0;
  logic [134:0] in_pkt_attributes = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [7:0]   out_proto;
  logic [31:0]  out_ip_src;
  logic [31:0]  out_ip_dst;
  logic [15:0]  out_port_src;
  logic [15:0]  out_port_dst;
  logic [15:0]  out_bytes;
  logic [4:0]   out_flags;
  logic [1:0]   out_prtcl_id;
  logic [7:0]   out_input_if;
  logic [2:0]   out_input_port;
  logic         out_if_err;
  logic         clear_counters = 1'b0;
  logic [31:0]  drop_count;
  logic         fifo_full;
  logic         fifo_empty;
  logic [127:0] prtcl_counts;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [134:0] a;
    logic [2:0]   port;
    logic         err;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  logic [134:0] mon_got;

  attr_record_decoder dut (
    .clk               (clk),
    .reset             (reset),
    .in_pkt_valid      (in_pkt_valid),
    .in_pkt_attributes (in_pkt_attributes),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_proto         (out_proto),
    .out_ip_src        (out_ip_src),
    .out_ip_dst        (out_ip_dst),
    .out_port_src      (out_port_src),
    .out_port_dst      (out_port_dst),
    .out_bytes         (out_bytes),
    .out_flags         (out_flags),
    .out_prtcl_id      (out_prtcl_id),
    .out_input_if      (out_input_if),
    .out_input_port    (out_input_port),
    .out_if_err        (out_if_err),
    .clear_counters    (clear_counters),
    .drop_count        (drop_count),
    .fifo_full         (fifo_full),
    .fifo_empty        (fifo_empty),
    .prtcl_counts      (prtcl_counts)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [134:0] mk(
    input logic [7:0]  proto,
    input logic [31:0] src,
    input logic [31:0] dst,
    input logic [15:0] ps,
    input logic [15:0] pd,
    input logic [15:0] bytes,
    input logic [4:0]  fl,
    input logic [1:0]  id,
    input logic [7:0]  inif
  );
    return {inif, id, fl, bytes, pd, ps, dst, src, proto};
  endfunction

  function automatic logic [2:0] exp_port(input logic [7:0] v);
    logic [2:0] p;
    p = '0;
    if ($countones(v) == 1)
      for (int i = 0; i < 8; i++) if (v[i]) p = 3'(i);
    return p;
  endfunction

  function automatic logic [134:0] cur();
    return {out_input_if, out_prtcl_id, out_flags, out_bytes,
            out_port_dst, out_port_src, out_ip_dst, out_ip_src, out_proto};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [134:0] a, input bit acc);
    logic [7:0] v;
    v = a[134:127];
    in_pkt_valid      = 1'b1;
    in_pkt_attributes = a;
    if (acc)
      sb.push_back('{a: a, port: exp_port(v), err: ($countones(v) != 1)});
    tick();
    in_pkt_valid = 1'b0;
  endtask

  task automatic drain(output bit ok);
    int n;
    n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    ok = (sb.size() == 0);
  endtask

  // Every accepted handshake is checked against the scoreboard head.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      total++;
      mon_got = cur();
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_record got=%h", mon_got);
      end else begin
        mon_e = sb.pop_front();
        if (mon_got !== mon_e.a || out_input_port !== mon_e.port ||
            out_if_err !== mon_e.err) begin
          bad++;
          $display("FAIL record got=%h port=%0d err=%0b exp=%h port=%0d err=%0b",
                   mon_got, out_input_port, out_if_err,
                   mon_e.a, mon_e.port, mon_e.err);
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++;
    if (out_valid !== 1'b0 || fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags got v=%b e=%b f=%b exp v=0 e=1 f=0",
               out_valid, fifo_empty, fifo_full);
    end
    total++;
    if (drop_count !== 32'd0 || prtcl_counts !== '0 || cur() !== '0 ||
        out_input_port !== 3'd0 || out_if_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_values got drop=%0d fields=%h exp 0", drop_count, cur());
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic [134:0] a;
    out_ready = 1'b0;
    a = mk(8'h06, 32'h0A000001, 32'h0A000002, 16'h1234, 16'h0050,
           16'd64, 5'h03, 2'd2, 8'h04);
    send(a, 1'b1);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_lat_n1 got=%b exp=0", out_valid);
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || cur() !== a || out_input_port !== 3'd2 ||
        out_if_err !== 1'b0) begin
      bad++;
      $display("FAIL single_lat_n2 got v=%b f=%h p=%0d e=%b exp v=1 f=%h p=2 e=0",
               out_valid, cur(), out_input_port, out_if_err, a);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || cur() !== a) begin
        bad++;
        $display("FAIL single_hold%0d got v=%b f=%h exp v=1 f=%h",
                 i, out_valid, cur(), a);
      end
    end
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || fifo_empty !== 1'b1) begin
      bad++;
      $display("FAIL single_accept got v=%b e=%b exp v=0 e=1", out_valid, fifo_empty);
    end
    out_ready = 1'b0;
    tick();
  endtask

  task automatic test_overflow();
    bit ok;
    out_ready = 1'b0;
    for (int i = 1; i <= 12; i++)
      send(mk(8'h11, 32'h1, 32'h2, 16'h3, 16'h4, 16'(i), 5'h0, 2'd0, 8'h01),
           i <= 9);
    @(negedge clk);
    total++;
    if (fifo_full !== 1'b1 || drop_count !== 32'd3) begin
      bad++;
      $display("FAIL overflow_full got full=%b drop=%0d exp full=1 drop=3",
               fifo_full, drop_count);
    end
    tick();
    drain(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL overflow_drain left=%0d exp 0", sb.size());
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL overflow_end got=%b exp=0", out_valid);
    end
    out_ready = 1'b0;
    tick();
  endtask

  task automatic test_full_pop_push();
    bit ok;
    out_ready = 1'b0;
    for (int i = 1; i <= 9; i++)
      send(mk(8'h22, 32'h5, 32'h6, 16'h7, 16'h8, 16'h100 + 16'(i), 5'h1,
              2'd1, 8'h02), 1'b1);
    @(negedge clk);
    total++;
    if (fifo_full !== 1'b1) begin
      bad++;
      $display("FAIL fpp_full got=%b exp=1", fifo_full);
    end
    tick();
    out_ready = 1'b1;
    send(mk(8'h22, 32'h5, 32'h6, 16'h7, 16'h8, 16'h1AA, 5'h1, 2'd1, 8'h02),
         1'b1);
    @(negedge clk);
    total++;
    if (drop_count !== 32'd3) begin
      bad++;
      $display("FAIL fpp_drop got=%0d exp=3", drop_count);
    end
    drain(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL fpp_drain left=%0d exp 0", sb.size());
    end
    out_ready = 1'b0;
    tick();
  endtask

  task automatic test_if_decode();
    bit ok;
    logic [7:0] ifs [3];
    ifs[0] = 8'h00;
    ifs[1] = 8'h05;
    ifs[2] = 8'h80;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++)
      send(mk(8'h33, 32'h9, 32'hA, 16'hB, 16'hC, 16'h200 + 16'(i), 5'h2,
              2'd3, ifs[i]), 1'b1);
    drain(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL ifdec_drain left=%0d exp 0", sb.size());
    end
    out_ready = 1'b0;
    tick();
  endtask

  task automatic test_clear();
    bit ok;
    out_ready = 1'b0;
    for (int i = 1; i <= 9; i++)
      send(mk(8'h44, 32'h1, 32'h1, 16'h1, 16'h1, 16'h300 + 16'(i), 5'h0,
              2'd0, 8'h08), 1'b1);
    clear_counters = 1'b1;
    send(mk(8'h44, 32'h1, 32'h1, 16'h1, 16'h1, 16'h3FF, 5'h0, 2'd0, 8'h08),
         1'b0);
    clear_counters = 1'b0;
    @(negedge clk);
    total++;
    if (drop_count !== 32'd0) begin
      bad++;
      $display("FAIL clear_drop got=%0d exp=0", drop_count);
    end
    tick();
    send(mk(8'h44, 32'h1, 32'h1, 16'h1, 16'h1, 16'h3FE, 5'h0, 2'd0, 8'h08),
         1'b0);
    @(negedge clk);
    total++;
    if (drop_count !== 32'd1) begin
      bad++;
      $display("FAIL post_clear_drop got=%0d exp=1", drop_count);
    end
    tick();
    drain(ok);
    for (int i = 0; i < 4; i++)
      send(mk(8'h55, 32'h2, 32'h2, 16'h2, 16'h2, 16'h400 + 16'(i), 5'h0,
              (i < 3) ? 2'd1 : 2'd3, 8'h10), 1'b1);
    drain(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL clear_drain left=%0d exp 0", sb.size());
    end
    @(negedge clk);
    total++;
`ifdef ATTR_DECODER_STATS_EN
    if (prtcl_counts[31:0] !== 32'd0 || prtcl_counts[63:32] !== 32'd3 ||
        prtcl_counts[95:64] !== 32'd0 || prtcl_counts[127:96] !== 32'd1) begin
      bad++;
      $display("FAIL prtcl_counts got=%h exp=%h", prtcl_counts,
               {32'd1, 32'd0, 32'd3, 32'd0});
    end
`else
    if (prtcl_counts !== '0) begin
      bad++;
      $display("FAIL prtcl_counts got=%h exp=0", prtcl_counts);
    end
`endif
    out_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_drain();
    bit ok;
    logic [134:0] y;
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++)
      send(mk(8'h66, 32'h3, 32'h3, 16'h3, 16'h3, 16'h500 + 16'(i), 5'h0,
              2'd2, 8'h20), 1'b1);
    tick();
    tick();
    out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || fifo_empty !== 1'b1 || fifo_full !== 1'b0 ||
        drop_count !== 32'd0) begin
      bad++;
      $display("FAIL mid_reset got v=%b e=%b f=%b d=%0d exp v=0 e=1 f=0 d=0",
               out_valid, fifo_empty, fifo_full, drop_count);
    end
    sb.delete();
    out_ready = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    y = mk(8'h77, 32'hC0A80001, 32'hC0A80002, 16'hAAAA, 16'h5555, 16'h0600,
           5'h1F, 2'd3, 8'h40);
    send(y, 1'b1);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_lat_n1 got=%b exp=0", out_valid);
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || cur() !== y || out_input_port !== 3'd6) begin
      bad++;
      $display("FAIL rst_lat_n2 got v=%b f=%h p=%0d exp v=1 f=%h p=6",
               out_valid, cur(), out_input_port, y);
    end
    tick();
    drain(ok);
    @(negedge clk);
    total++;
    if (!ok || out_valid !== 1'b0 || fifo_empty !== 1'b1) begin
      bad++;
      $display("FAIL rst_alone got left=%0d v=%b e=%b exp left=0 v=0 e=1",
               sb.size(), out_valid, fifo_empty);
    end
    out_ready = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_full_pop_push();
    test_if_decode();
    test_clear();
    test_reset_mid_drain();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
